// File: rtl/if_id_queue_pkg.sv
// if_id_queue_pkg
//   Shared constants, types and helpers for the fetch-to-decode queue.
//   The former global defines live here as typed localparams:
//     ZERO_WORD   - bubble value driven on id_* when the queue is empty
//     BRANCH      - active level of the branch-redirect flush
//     INST_W      - instruction bus width
//   q_op_e names the single operation the queue performs on a clock edge.
package if_id_queue_pkg;

  localparam int unsigned INST_W = 32;

  localparam logic              BRANCH    = 1'b1;
  localparam logic [INST_W-1:0] ZERO_WORD = '0;

  // Exactly one of these applies per edge; flush dominates everything else.
  typedef enum logic [2:0] {
    Q_IDLE,
    Q_PUSH,
    Q_POP,
    Q_PUSH_POP,
    Q_FLUSH
  } q_op_e;

  // Reverse byte order of a 32-bit word (memory order -> decode order).
  function automatic logic [INST_W-1:0] byte_swap32(input logic [INST_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/if_id_queue_if.sv
// if_id_queue_if
//   Handshake bundle between the fetch stage, the if/id queue and decode.
//   Parameters must match the queue instance they connect to.
//     if_valid / if_ready / if_pc / if_inst : fetch-side push handshake
//     id_valid / id_ready / id_pc / id_inst : decode-side pop handshake
//     count                                 : occupied entries
//   Modports:
//     slave  - the queue itself
//     master - the surrounding pipeline (fetch + decode)
interface if_id_queue_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 4
) ();
  import if_id_queue_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              if_valid;
  logic              if_ready;
  logic [ADDR_W-1:0] if_pc;
  logic [INST_W-1:0] if_inst;

  logic              id_valid;
  logic              id_ready;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;

  logic [CNT_W-1:0]  count;

  modport slave (
    input  if_valid, if_pc, if_inst, id_ready,
    output if_ready, id_valid, id_pc, id_inst, count
  );

  modport master (
    output if_valid, if_pc, if_inst, id_ready,
    input  if_ready, id_valid, id_pc, id_inst, count
  );

endinterface

// File: rtl/if_id_queue_mem.sv
// if_id_queue_mem
//   Entry storage for the if/id queue: DEPTH words of WIDTH bits,
//   one synchronous write port and one asynchronous read port.
//   Contents are never cleared; validity is tracked by the controller.
//     clk   - write clock
//     we    - write enable
//     waddr - write index
//     wdata - write data
//     raddr - read index
//     rdata - read data (combinational)
module if_id_queue_mem #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 64,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// if_id_queue
//   Small FIFO between instruction fetch and decode. Fetch pushes
//   {pc, inst} (inst optionally byte-reversed on entry); decode pops the
//   head. No in-to-out bypass: a push becomes visible after its edge.
//   Ports:
//     clk               - clock, rising edge
//     rst               - asynchronous active-low reset
//     flush_from_branch - branch redirect; clears the queue, drops input
//     bus (slave)       - fetch/decode handshake, see if_id_queue_if
//   Parameters:
//     DEPTH     - entries (2, 4, 8 or 16)
//     ADDR_W    - PC width
//     BYTE_SWAP - 1: reverse instruction bytes on entry, 0: pass through
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter bit          BYTE_SWAP = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush_from_branch,
  if_id_queue_if.slave   bus
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned ENTRY_W = ADDR_W + INST_W;

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   cnt;

  logic               flush;
  logic               not_full;
  logic               not_empty;
  logic               push;
  logic               pop;
  q_op_e              op;

  logic [INST_W-1:0]  inst_in;
  logic [ENTRY_W-1:0] wdata;
  logic [ENTRY_W-1:0] rdata;

  // Full/empty come from the registered count only, so a pop in the same
  // cycle never opens a slot for a push (no full-bypass path).
  assign flush     = (flush_from_branch == BRANCH);
  assign not_full  = (cnt < CNT_W'(DEPTH));
  assign not_empty = (cnt != '0);

  assign push = bus.if_valid & not_full  & ~flush;
  assign pop  = bus.id_ready & not_empty & ~flush;

  always_comb begin
    op = Q_IDLE;
    if (flush) begin
      op = Q_FLUSH;
    end else begin
      unique case ({push, pop})
        2'b10:   op = Q_PUSH;
        2'b01:   op = Q_POP;
        2'b11:   op = Q_PUSH_POP;
        default: op = Q_IDLE;
      endcase
    end
  end

  // DEPTH is a power of two, so pointer increments wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      unique case (op)
        Q_FLUSH: begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          cnt    <= '0;
        end
        Q_PUSH: begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          cnt    <= cnt + CNT_W'(1);
        end
        Q_POP: begin
          rd_ptr <= rd_ptr + PTR_W'(1);
          cnt    <= cnt - CNT_W'(1);
        end
        Q_PUSH_POP: begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

  generate
    if (BYTE_SWAP) begin : g_swap
      assign inst_in = byte_swap32(bus.if_inst);
    end else begin : g_pass
      assign inst_in = bus.if_inst;
    end
  endgenerate

  assign wdata = {bus.if_pc, inst_in};

  if_id_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Stale storage is masked to a bubble whenever the queue is empty.
  assign bus.if_ready = not_full;
  assign bus.id_valid = not_empty;
  assign bus.id_pc    = not_empty ? rdata[ENTRY_W-1 -: ADDR_W] : '0;
  assign bus.id_inst  = not_empty ? rdata[INST_W-1:0] : ZERO_WORD;
  assign bus.count    = cnt;

endmodule
